tank_move_scheduler: RTL

- Once per video frame, walks every tank slot in index order and applies that slot's latched direction command to its x/y/direction registers.
- Enforces playfield bounds, and optionally tank-to-tank collision, using one shared step/compare datapath.
- Owns the tank position register file; flat buses feed the pixel renderer.
- Runs in the 25 MHz pixel domain, triggered from vertical blank.

---
 rtl/tank_pkg.sv | 37 +++
 rtl/tank_move_scheduler_if.sv | 24 ++
 rtl/tank_step_calc.sv | 50 +++++
 rtl/tank_move_scheduler.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared constants for the tank movement scheduler: direction/command encodings,
// playfield limits, the sweep FSM state type and the slot home-position helper.
package tank_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [3:0] CMD_UP    = 4'b1000;
    localparam logic [3:0] CMD_DOWN  = 4'b0100;
    localparam logic [3:0] CMD_LEFT  = 4'b0010;
    localparam logic [3:0] CMD_RIGHT = 4'b0001;

    localparam logic [9:0] X_MIN      = 10'd2;
    localparam logic [9:0] X_MAX      = 10'd609;
    localparam logic [9:0] Y_MIN      = 10'd1;
    localparam logic [9:0] Y_MAX      = 10'd449;
    localparam logic [9:0] STEP       = 10'd1;
    localparam logic [9:0] TANK_SIZE  = 10'd30;
    localparam logic [9:0] HOME_PITCH = 10'd96;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_CALC,
        ST_CHECK,
        ST_COMMIT,
        ST_FIN
    } sched_state_t;

    // Slots start spread along the top wall, one pitch apart.
    function automatic logic [9:0] tank_home_x(input int unsigned slot);
        return X_MIN + 10'(HOME_PITCH * slot);
    endfunction

endpackage

// File: rtl/tank_move_scheduler_if.sv
// Command/status bundle between the game logic (master) and the move scheduler (slave).
interface tank_move_scheduler_if #(
    parameter int NUM_TANKS = 5
);
    logic                      frame_tick;
    logic [4*NUM_TANKS-1:0]    cmd_dir;
    logic [NUM_TANKS-1:0]      tank_alive;
    logic [10*NUM_TANKS-1:0]   tank_x;
    logic [10*NUM_TANKS-1:0]   tank_y;
    logic [2*NUM_TANKS-1:0]    tank_dir;
    logic                      busy;
    logic                      done;
    logic                      overrun;

    modport master (
        output frame_tick, cmd_dir, tank_alive,
        input  tank_x, tank_y, tank_dir, busy, done, overrun
    );

    modport slave (
        input  frame_tick, cmd_dir, tank_alive,
        output tank_x, tank_y, tank_dir, busy, done, overrun
    );
endinterface

// File: rtl/tank_step_calc.sv
// Combinational step for one slot: one-hot command decode, +/-STEP on one axis,
// and wall clamp evaluated in 11 bits so a step below zero cannot wrap.
module tank_step_calc
    import tank_pkg::*;
(
    input  logic       alive,
    input  logic [3:0] cmd,
    input  logic [9:0] cur_x,
    input  logic [9:0] cur_y,
    input  logic [1:0] cur_dir,
    output logic [9:0] nxt_x,
    output logic [9:0] nxt_y,
    output logic [1:0] nxt_dir
);
    logic [10:0] cand_x;
    logic [10:0] cand_y;
    logic        in_bounds;

    always_comb begin
        cand_x  = {1'b0, cur_x};
        cand_y  = {1'b0, cur_y};
        nxt_dir = cur_dir;
        if (alive) begin
            case (cmd)
                CMD_UP: begin
                    cand_y  = {1'b0, cur_y} - {1'b0, STEP};
                    nxt_dir = DIR_UP;
                end
                CMD_DOWN: begin
                    cand_y  = {1'b0, cur_y} + {1'b0, STEP};
                    nxt_dir = DIR_DOWN;
                end
                CMD_LEFT: begin
                    cand_x  = {1'b0, cur_x} - {1'b0, STEP};
                    nxt_dir = DIR_LEFT;
                end
                CMD_RIGHT: begin
                    cand_x  = {1'b0, cur_x} + {1'b0, STEP};
                    nxt_dir = DIR_RIGHT;
                end
                default: ;
            endcase
        end
        // A blocked move still turns the tank; only the position is held.
        in_bounds = (cand_x >= {1'b0, X_MIN}) && (cand_x <= {1'b0, X_MAX}) &&
                    (cand_y >= {1'b0, Y_MIN}) && (cand_y <= {1'b0, Y_MAX});
        nxt_x = in_bounds ? cand_x[9:0] : cur_x;
        nxt_y = in_bounds ? cand_y[9:0] : cur_y;
    end
endmodule

// File: rtl/tank_move_scheduler.sv
// Per-frame tank movement sweep owning the position register file.
// Optional tank-to-tank collision check is enabled by defining TANK_COLLIDE_EN.
module tank_move_scheduler
    import tank_pkg::*;
#(
    parameter int NUM_TANKS = 5
)
(
    input  logic                  clk_25m,
    input  logic                  rst,
    tank_move_scheduler_if.slave  bus
);
    localparam int              IDX_W    = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TANKS - 1);

    sched_state_t           state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg;
    logic [4*NUM_TANKS-1:0] cmd_shadow_reg;
    logic [NUM_TANKS-1:0]   alive_shadow_reg;
    logic [9:0]             tank_x_reg   [NUM_TANKS];
    logic [9:0]             tank_y_reg   [NUM_TANKS];
    logic [1:0]             tank_dir_reg [NUM_TANKS];
    logic [9:0]             cand_x_reg, cand_y_reg;
    logic [1:0]             cand_dir_reg;
    logic [9:0]             step_x, step_y;
    logic [1:0]             step_dir;
    logic [9:0]             commit_x, commit_y;
    logic                   busy_reg, done_reg, overrun_reg;

    tank_step_calc u_step (
        .alive   (alive_shadow_reg[idx_reg]),
        .cmd     (cmd_shadow_reg[4*idx_reg +: 4]),
        .cur_x   (tank_x_reg[idx_reg]),
        .cur_y   (tank_y_reg[idx_reg]),
        .cur_dir (tank_dir_reg[idx_reg]),
        .nxt_x   (step_x),
        .nxt_y   (step_y),
        .nxt_dir (step_dir)
    );

`ifdef TANK_COLLIDE_EN
    logic [IDX_W-1:0]   chk_idx_reg;
    logic               hit_reg;
    logic               hit_now;
    logic signed [10:0] dx, dy;
    logic [10:0]        abs_dx, abs_dy;

    // Candidate box against slot chk_idx's committed box; self and dead slots never hit.
    always_comb begin
        dx      = $signed({1'b0, cand_x_reg}) - $signed({1'b0, tank_x_reg[chk_idx_reg]});
        dy      = $signed({1'b0, cand_y_reg}) - $signed({1'b0, tank_y_reg[chk_idx_reg]});
        abs_dx  = (dx < 0) ? $unsigned(-dx) : $unsigned(dx);
        abs_dy  = (dy < 0) ? $unsigned(-dy) : $unsigned(dy);
        hit_now = alive_shadow_reg[chk_idx_reg] && (chk_idx_reg != idx_reg) &&
                  (abs_dx < {1'b0, TANK_SIZE}) && (abs_dy < {1'b0, TANK_SIZE});
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            chk_idx_reg <= '0;
            hit_reg     <= 1'b0;
        end else if (state_reg == ST_CALC) begin
            chk_idx_reg <= '0;
            hit_reg     <= 1'b0;
        end else if (state_reg == ST_CHECK) begin
            chk_idx_reg <= chk_idx_reg + 1'b1;
            hit_reg     <= hit_reg | hit_now;
        end
    end

    assign commit_x = hit_reg ? tank_x_reg[idx_reg] : cand_x_reg;
    assign commit_y = hit_reg ? tank_y_reg[idx_reg] : cand_y_reg;
`else
    assign commit_x = cand_x_reg;
    assign commit_y = cand_y_reg;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.frame_tick) state_next = ST_SNAP;
            ST_SNAP:   state_next = ST_CALC;
`ifdef TANK_COLLIDE_EN
            ST_CALC:   state_next = ST_CHECK;
            ST_CHECK:  if (chk_idx_reg == LAST_IDX) state_next = ST_COMMIT;
`else
            ST_CALC:   state_next = ST_COMMIT;
`endif
            ST_COMMIT: state_next = (idx_reg == LAST_IDX) ? ST_FIN : ST_CALC;
            ST_FIN:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            idx_reg          <= '0;
            cmd_shadow_reg   <= '0;
            alive_shadow_reg <= '0;
            cand_x_reg       <= '0;
            cand_y_reg       <= '0;
            cand_dir_reg     <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            busy_reg    <= (state_next != ST_IDLE) && (state_next != ST_FIN);
            done_reg    <= (state_next == ST_FIN);
            // A tick is only accepted in IDLE; any other state drops it and flags it.
            overrun_reg <= bus.frame_tick && (state_reg != ST_IDLE);
            case (state_reg)
                ST_SNAP: begin
                    cmd_shadow_reg   <= bus.cmd_dir;
                    alive_shadow_reg <= bus.tank_alive;
                    idx_reg          <= '0;
                end
                ST_CALC: begin
                    cand_x_reg   <= step_x;
                    cand_y_reg   <= step_y;
                    cand_dir_reg <= step_dir;
                end
                ST_COMMIT: if (idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_25m) begin
        for (int i = 0; i < NUM_TANKS; i++) begin
            if (rst) begin
                tank_x_reg[i]   <= tank_home_x($unsigned(i));
                tank_y_reg[i]   <= Y_MIN;
                tank_dir_reg[i] <= DIR_UP;
            end else if ((state_reg == ST_COMMIT) && (idx_reg == IDX_W'(i))) begin
                tank_x_reg[i]   <= commit_x;
                tank_y_reg[i]   <= commit_y;
                tank_dir_reg[i] <= cand_dir_reg;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_TANKS; gi++) begin : g_flat
        assign bus.tank_x[10*gi +: 10]  = tank_x_reg[gi];
        assign bus.tank_y[10*gi +: 10]  = tank_y_reg[gi];
        assign bus.tank_dir[2*gi +: 2]  = tank_dir_reg[gi];
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.overrun = overrun_reg;
endmodule
